// File: rtl/key_evt_pkg.sv
// Shared types and constants for the key gesture classifier.
// Holds the FSM state encoding, the event codes and a small max helper.
package key_evt_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      WAIT2  = 3'd2,
      PRESS2 = 3'd3,
      HOLD   = 3'd4
   } state_t;

   localparam logic [2:0] EVT_NONE   = 3'd0;
   localparam logic [2:0] EVT_SHORT  = 3'd1;
   localparam logic [2:0] EVT_LONG   = 3'd2;
   localparam logic [2:0] EVT_DOUBLE = 3'd3;
   localparam logic [2:0] EVT_REPEAT = 3'd4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_event_fsm.sv
// Classifies a debounced active-low key into short, long, double and repeat events.
// All event outputs are registered; busy is decoded directly from the state.
module key_event_fsm
   import key_evt_pkg::*;
#(
   parameter int LONG_CYC = 25_000_000,
   parameter int DBL_CYC  = 12_500_000,
   parameter int REP_CYC  = 5_000_000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       btn_lvl,
   output logic       evt_short,
   output logic       evt_long,
   output logic       evt_double,
   output logic       evt_repeat,
   output logic [2:0] evt_code,
   output logic       busy
);

   localparam int MAX_CYC = max3(LONG_CYC, DBL_CYC, REP_CYC);
   localparam int CNT_W   = $clog2(MAX_CYC);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             lvl_d;
   logic             prs_edge;
   logic             rel_edge;

   assign prs_edge = lvl_d & ~btn_lvl;
   assign rel_edge = ~lvl_d & btn_lvl;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         // lvl_d tracks the key during reset so a held key gives no press edge
         state      <= IDLE;
         cnt        <= '0;
         lvl_d      <= btn_lvl;
         evt_short  <= 1'b0;
         evt_long   <= 1'b0;
         evt_double <= 1'b0;
         evt_repeat <= 1'b0;
         evt_code   <= EVT_NONE;
      end else begin
         lvl_d      <= btn_lvl;
         evt_short  <= 1'b0;
         evt_long   <= 1'b0;
         evt_double <= 1'b0;
         evt_repeat <= 1'b0;
         case (state)
            IDLE: begin
               if (prs_edge) begin
                  state <= PRESS1;
                  cnt   <= '0;
               end
            end
            PRESS1: begin
               // release takes priority over the long-press threshold
               if (rel_edge) begin
                  state <= WAIT2;
                  cnt   <= '0;
               end else if (cnt == LONG_LAST && !btn_lvl) begin
                  evt_long <= 1'b1;
                  evt_code <= EVT_LONG;
                  state    <= HOLD;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT2: begin
               if (prs_edge) begin
                  state <= PRESS2;
                  cnt   <= '0;
               end else if (cnt == DBL_LAST) begin
                  evt_short <= 1'b1;
                  evt_code  <= EVT_SHORT;
                  state     <= IDLE;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESS2: begin
               if (rel_edge) begin
                  evt_double <= 1'b1;
                  evt_code   <= EVT_DOUBLE;
                  state      <= IDLE;
                  cnt        <= '0;
               end
            end
            HOLD: begin
               if (rel_edge) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == REP_LAST) begin
                  evt_repeat <= 1'b1;
                  evt_code   <= EVT_REPEAT;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_event_fsm.sv
// Directed bench for key_event_fsm with LONG_CYC=16, DBL_CYC=8, REP_CYC=4.
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_key_event_fsm;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       btn_lvl = 1'b1;
   logic       evt_short;
   logic       evt_long;
   logic       evt_double;
   logic       evt_repeat;
   logic [2:0] evt_code;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;
   int n_short = 0;
   int n_long = 0;
   int n_double = 0;
   int n_repeat = 0;
   int n_multi = 0;

   key_event_fsm #(.LONG_CYC(16), .DBL_CYC(8), .REP_CYC(4)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .btn_lvl    (btn_lvl),
      .evt_short  (evt_short),
      .evt_long   (evt_long),
      .evt_double (evt_double),
      .evt_repeat (evt_repeat),
      .evt_code   (evt_code),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // pulse tallies, sampled mid-cycle
   always @(negedge clk) begin
      if (evt_short === 1'b1)  n_short++;
      if (evt_long === 1'b1)   n_long++;
      if (evt_double === 1'b1) n_double++;
      if (evt_repeat === 1'b1) n_repeat++;
      if ((int'(evt_short) + int'(evt_long) + int'(evt_double) + int'(evt_repeat)) > 1) n_multi++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic clr_counts();
      n_short = 0;
      n_long = 0;
      n_double = 0;
      n_repeat = 0;
   endtask

   task automatic chk_counts(input string tag, input int s, input int l, input int d, input int r);
      chk({tag, "_n_short"}, n_short, s);
      chk({tag, "_n_long"}, n_long, l);
      chk({tag, "_n_double"}, n_double, d);
      chk({tag, "_n_repeat"}, n_repeat, r);
   endtask

   initial begin
      // reset with the key released
      rstn = 1'b0;
      btn_lvl = 1'b1;
      ticks(2);
      chk("rst_short", evt_short, 0);
      chk("rst_long", evt_long, 0);
      chk("rst_double", evt_double, 0);
      chk("rst_repeat", evt_repeat, 0);
      chk("rst_code", evt_code, 0);
      chk("rst_busy", busy, 0);
      rstn = 1'b1;
      ticks(3);
      clr_counts();

      // short press: 5 cycles low, release, short 9 edges after release
      btn_lvl = 1'b0;
      tick();
      chk("t1_busy_press", busy, 1);
      ticks(4);
      btn_lvl = 1'b1;
      tick();
      ticks(7);
      chk("t1_short_early", evt_short, 0);
      tick();
      chk("t1_short", evt_short, 1);
      chk("t1_code", evt_code, 1);
      chk("t1_busy_idle", busy, 0);
      tick();
      chk("t1_short_one_cycle", evt_short, 0);
      ticks(12);
      chk_counts("t1", 1, 0, 0, 0);
      clr_counts();

      // long press with three repeats, release gives no short
      btn_lvl = 1'b0;
      tick();
      ticks(15);
      chk("t2_long_early", evt_long, 0);
      tick();
      chk("t2_long", evt_long, 1);
      chk("t2_code_long", evt_code, 2);
      chk("t2_busy_hold", busy, 1);
      for (int k = 0; k < 3; k++) begin
         ticks(3);
         chk("t2_repeat_early", evt_repeat, 0);
         tick();
         chk("t2_repeat", evt_repeat, 1);
         chk("t2_code_repeat", evt_code, 4);
      end
      tick();
      btn_lvl = 1'b1;
      tick();
      chk("t2_busy_release", busy, 0);
      ticks(12);
      chk_counts("t2", 0, 1, 0, 3);
      chk("t2_code_held", evt_code, 4);
      clr_counts();

      // double click with a long second press
      btn_lvl = 1'b0;
      ticks(3);
      btn_lvl = 1'b1;
      ticks(3);
      btn_lvl = 1'b0;
      ticks(40);
      chk("t3_busy_press2", busy, 1);
      btn_lvl = 1'b1;
      tick();
      chk("t3_double", evt_double, 1);
      chk("t3_code", evt_code, 3);
      chk("t3_busy_idle", busy, 0);
      ticks(20);
      chk_counts("t3", 0, 0, 1, 0);
      clr_counts();

      // release sampled exactly at the long threshold: release wins
      btn_lvl = 1'b0;
      ticks(16);
      btn_lvl = 1'b1;
      tick();
      chk("b1_no_long", evt_long, 0);
      chk("b1_busy", busy, 1);
      ticks(7);
      chk("b1_short_early", evt_short, 0);
      tick();
      chk("b1_short", evt_short, 1);
      chk("b1_code", evt_code, 1);
      ticks(5);
      chk_counts("b1", 1, 0, 0, 0);
      clr_counts();

      // second press sampled exactly at the double-click timeout: press wins
      btn_lvl = 1'b0;
      ticks(3);
      btn_lvl = 1'b1;
      ticks(8);
      btn_lvl = 1'b0;
      tick();
      chk("b2_no_short", evt_short, 0);
      chk("b2_busy", busy, 1);
      ticks(3);
      btn_lvl = 1'b1;
      tick();
      chk("b2_double", evt_double, 1);
      chk("b2_code", evt_code, 3);
      ticks(12);
      chk_counts("b2", 0, 0, 1, 0);
      clr_counts();

      // key held through reset: no press edge afterwards
      btn_lvl = 1'b0;
      rstn = 1'b0;
      ticks(2);
      chk("t4_rst_code", evt_code, 0);
      rstn = 1'b1;
      ticks(20);
      chk("t4_busy_held", busy, 0);
      btn_lvl = 1'b1;
      tick();
      chk("t4_busy_release", busy, 0);
      ticks(3);
      chk_counts("t4_held", 0, 0, 0, 0);
      btn_lvl = 1'b0;
      ticks(2);
      btn_lvl = 1'b1;
      tick();
      ticks(7);
      chk("t4_short_early", evt_short, 0);
      tick();
      chk("t4_short", evt_short, 1);
      chk("t4_code", evt_code, 1);
      ticks(5);
      chk_counts("t4", 1, 0, 0, 0);
      clr_counts();

      // reset while in HOLD, key stays held after reset
      btn_lvl = 1'b0;
      ticks(17);
      chk("t5_long", evt_long, 1);
      ticks(2);
      rstn = 1'b0;
      tick();
      chk("t5_rst_short", evt_short, 0);
      chk("t5_rst_long", evt_long, 0);
      chk("t5_rst_double", evt_double, 0);
      chk("t5_rst_repeat", evt_repeat, 0);
      chk("t5_rst_code", evt_code, 0);
      chk("t5_rst_busy", busy, 0);
      tick();
      rstn = 1'b1;
      ticks(20);
      chk("t5_busy_held", busy, 0);
      btn_lvl = 1'b1;
      ticks(12);
      chk("t5_code_after", evt_code, 0);
      chk_counts("t5", 0, 1, 0, 0);

      chk("one_hot_pulses", n_multi, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/key_event_fsm.md
Name: key_event_fsm

Overview:
- Sits directly downstream of the key debouncer.
- Consumes the debounced, stable key level (active-low: 0 = pressed, 1 = released).
- Classifies each gesture as short press, long press, double click, or auto-repeat while held.
- Emits one-cycle event pulses and a held event code, for LED/menu logic in examination designs.

Parameters:
- LONG_CYC, 25_000_000, hold cycles before a press counts as long (0.5 s at 50 MHz); must be >= 2
- DBL_CYC, 12_500_000, max cycles from first release to second press for a double click; must be >= 2
- REP_CYC, 5_000_000, auto-repeat period while held after a long press; must be >= 2

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rstn  in  1  synchronous reset, active-low
- btn_lvl  in  1  debounced key level, 0 = pressed; already synchronous to clk
- evt_short  out  1  one-cycle pulse: short press
- evt_long  out  1  one-cycle pulse: long press threshold reached
- evt_double  out  1  one-cycle pulse: double click
- evt_repeat  out  1  one-cycle pulse: auto-repeat tick
- evt_code  out  3  code of the last event: 0 none, 1 short, 2 long, 3 double, 4 repeat; held until the next event
- busy  out  1  1 whenever the FSM is not in IDLE

Behaviour:
- Reset: one clock with rstn = 0 applies it.
  - State = IDLE, cnt = 0.
  - All pulses = 0, evt_code = 0, busy = 0.
  - lvl_d loads btn_lvl, so a key already held during reset produces no press edge.
- Edge detection (lvl_d is btn_lvl delayed one cycle):
  - press = lvl_d & ~btn_lvl
  - release = ~lvl_d & btn_lvl
- Counter: cnt width = $clog2(max(LONG_CYC, DBL_CYC, REP_CYC)). cnt clears to 0 on every state entry.
- IDLE: on press, go to PRESS1.
- PRESS1: cnt increments each cycle.
  - On release, go to WAIT2.
  - Else, when cnt == LONG_CYC-1 with btn_lvl = 0, assert evt_long and go to HOLD.
  - If release and cnt == LONG_CYC-1 occur in the same cycle, release wins: no evt_long, go to WAIT2.
- WAIT2: cnt increments.
  - On press, go to PRESS2.
  - Else, when cnt == DBL_CYC-1, assert evt_short and go to IDLE.
  - If press and timeout occur in the same cycle, press wins.
- PRESS2: no timeout. On release, assert evt_double and go to IDLE. A second press held any length is still a double click.
- HOLD: cnt increments.
  - When cnt == REP_CYC-1, assert evt_repeat and reset cnt to 0.
  - On release, go to IDLE with no pulse. Release beats repeat in the same cycle.
- Outputs are registered: a pulse is high exactly one cycle, in the cycle after the deciding condition is sampled.
  - evt_code updates in the same cycle as its pulse.
  - At most one pulse is high in any cycle.
- Latency, with edges counted from the first edge sampling the new btn_lvl:
  - evt_long rises LONG_CYC+1 edges after the press is sampled.
  - evt_short rises DBL_CYC+1 edges after the release is sampled.
  - evt_double rises 1 edge after the second release is sampled.
  - evt_repeat rises every REP_CYC edges after evt_long.
- Reset mid-gesture aborts silently: no pulse is emitted, and the FSM returns to IDLE.
- busy is combinational from state: 1 in PRESS1, WAIT2, PRESS2, HOLD.

Decomposition:
- Package key_evt_pkg holds:
  - the state enum: IDLE, PRESS1, WAIT2, PRESS2, HOLD
  - the evt_code constants: EVT_NONE=0, EVT_SHORT=1, EVT_LONG=2, EVT_DOUBLE=3, EVT_REPEAT=4
- No sub-module: the edge detector is two lines, and the FSM and counter share one always block set.

Test Plan (LONG_CYC=16, DBL_CYC=8, REP_CYC=4):
- Press 5 cycles, release, idle 20 cycles -> single evt_short 9 edges after the release is sampled; evt_code=1; no other pulses; busy returns to 0.
- Press 30 cycles -> evt_long at press+17; evt_repeat at +21, +25, +29; release -> IDLE, no short; evt_code=4.
- Press 3, release 3, press 40, release -> no evt_short and no evt_long; single evt_double 1 edge after the final release is sampled; evt_code=3.
- Boundaries:
  - Release sampled in the cycle where cnt=15 in PRESS1 -> no evt_long, later evt_short.
  - Second press sampled in the cycle where cnt=7 in WAIT2 -> double, no short.
- Hold btn_lvl=0 through reset and release rstn -> no event until release; a subsequent press/release gives normal evt_short.
- Assert rstn=0 while in HOLD (2 cycles) -> all outputs 0 next cycle, evt_code=0, no pulse after rstn deasserts while still held.
